knn_seq_ctrl: RTL and testbench

KNN_SEQ_CTRL -- requirements
Module: knn_seq_ctrl

---
 rtl/knn_seq_ctrl.sv | 107 ++++++++++
 tb/tb_knn_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/knn_seq_ctrl.sv
// Sequencer for a KNN core: loads a serial query vector, sweeps the sample memory,
// waits for the core pipeline to settle, then holds the captured result until consumed.
module knn_seq_ctrl #(
  parameter int FEATURE_NUM = 7,
  parameter int LEN         = 13,
  parameter int DATA_WIDE   = 1,
  parameter int COM_NUM     = 600,
  parameter int ADDR_W      = 10,
  parameter int RD_LAT      = 1,
  parameter int PIPE_LAT    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       feat_valid,
  input  logic [LEN-1:0]             feat_data,
  output logic                       feat_ready,
  input  logic                       abort,
  output logic                       core_en,
  output logic [LEN*FEATURE_NUM-1:0] core_feature,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_WIDE-1:0]       core_result,
  output logic                       res_valid,
  output logic [DATA_WIDE-1:0]       res_data,
  input  logic                       res_ready,
  output logic                       busy
);

  typedef enum logic [1:0] {LOAD, SWEEP, DRAIN, DONE} state_t;

  localparam logic [4:0]        BEAT_LAST  = 5'(FEATURE_NUM - 1);
  localparam logic [4:0]        DRAIN_LAST = 5'(RD_LAT + PIPE_LAT);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(COM_NUM - 1);

  state_t                       state;
  logic [4:0]                   beat_cnt;
  logic [4:0]                   drain_cnt;
  logic [LEN*FEATURE_NUM-1:0]   vec;
  logic [LEN*(FEATURE_NUM+1)-1:0] vec_ext;
  logic                         beat_acc;

  // Extended concatenation keeps the shift legal when FEATURE_NUM is 1.
  assign vec_ext  = {feat_data, vec};
  assign beat_acc = feat_valid && (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      vec       <= '0;
      rom_addr  <= '0;
      res_data  <= '0;
    end else if (abort) begin
      state     <= LOAD;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      vec       <= '0;
      rom_addr  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (beat_acc) begin
            vec <= vec_ext[LEN*(FEATURE_NUM+1)-1:LEN];
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              state    <= SWEEP;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        SWEEP: begin
          if (rom_addr == ADDR_LAST) begin
            state <= DRAIN;
          end else begin
            rom_addr <= rom_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            res_data  <= core_result;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 5'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            rom_addr <= '0;
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign feat_ready   = (state == LOAD);
  assign busy         = (state != LOAD);
  assign core_en      = (state != LOAD);
  assign rom_en       = (state == SWEEP);
  assign res_valid    = (state == DONE);
  assign core_feature = core_en ? vec : '0;

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// Self-checking bench for knn_seq_ctrl: expected query vector/result pairs are queued
// when the final beat is driven and compared when the controller presents its result.
module tb_knn_seq_ctrl;

  localparam int FN  = 3;
  localparam int LN  = 4;
  localparam int DW  = 2;
  localparam int CN  = 4;
  localparam int AW  = 4;
  localparam int RL  = 1;
  localparam int PL  = 2;
  localparam int DRN = RL + PL + 1;
  // Cycles from the cycle the last beat is presented to res_valid high.
  localparam int LAT = 1 + CN + RL + PL + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              feat_valid;
  logic [LN-1:0]     feat_data;
  logic              feat_ready;
  logic              abort;
  logic              core_en;
  logic [LN*FN-1:0]  core_feature;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     core_result;
  logic              res_valid;
  logic [DW-1:0]     res_data;
  logic              res_ready;
  logic              busy;

  typedef struct packed {
    logic [LN*FN-1:0] vec;
    logic [DW-1:0]    res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  knn_seq_ctrl #(
    .FEATURE_NUM(FN), .LEN(LN), .DATA_WIDE(DW), .COM_NUM(CN),
    .ADDR_W(AW), .RD_LAT(RL), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_data(feat_data),
    .feat_ready(feat_ready), .abort(abort), .core_en(core_en),
    .core_feature(core_feature), .rom_en(rom_en), .rom_addr(rom_addr),
    .core_result(core_result), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [LN-1:0] d);
    feat_valid = 1'b1;
    feat_data  = d;
    tick();
    feat_valid = 1'b0;
    feat_data  = '0;
  endtask

  task automatic check_load(input string tag);
    check({tag, ".feat_ready"},   32'(feat_ready),   1);
    check({tag, ".busy"},         32'(busy),         0);
    check({tag, ".core_en"},      32'(core_en),      0);
    check({tag, ".rom_en"},       32'(rom_en),       0);
    check({tag, ".res_valid"},    32'(res_valid),    0);
    check({tag, ".core_feature"}, 32'(core_feature), 0);
    check({tag, ".rom_addr"},     32'(rom_addr),     0);
  endtask

  // Entered at the first SWEEP sample; walks sweep and drain, then the result handshake.
  task automatic run_result(input bit hold);
    exp_t e;
    int   cyc;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e         = exp_q[0];
    res_ready = !hold;
    cyc       = 1;
    for (int t = 0; t < CN + DRN; t++) begin
      // Only the value present before the final drain edge may be captured.
      core_result = (t == CN + DRN - 1) ? e.res : ~e.res;
      check("run.core_en",      32'(core_en),      1);
      check("run.core_feature", 32'(core_feature), 32'(e.vec));
      check("run.feat_ready",   32'(feat_ready),   0);
      check("run.res_valid",    32'(res_valid),    0);
      if (t < CN) begin
        check("sweep.rom_en",   32'(rom_en),   1);
        check("sweep.rom_addr", 32'(rom_addr), 32'(t));
      end else begin
        check("drain.rom_en",   32'(rom_en),   0);
        check("drain.rom_addr", 32'(rom_addr), CN - 1);
      end
      tick();
      cyc++;
    end
    core_result = ~e.res;
    e = exp_q.pop_front();
    check("done.res_valid", 32'(res_valid), 1);
    check("done.latency",   32'(res_valid ? cyc : 0), LAT);
    check("done.res_data",  32'(res_data),  32'(e.res));
    check("done.core_en",   32'(core_en),   1);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        feat_valid = 1'b1;
        feat_data  = 4'hF;
        tick();
        check("hold.res_valid",  32'(res_valid),  1);
        check("hold.res_data",   32'(res_data),   32'(e.res));
        check("hold.feat_ready", 32'(feat_ready), 0);
      end
      feat_valid = 1'b0;
      res_ready  = 1'b1;
    end
    tick();
    check_load("after_done");
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; feat_valid = 1'b0; feat_data = '0;
    core_result = '0; res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_load("reset");
    check("reset.res_data", 32'(res_data), 0);

    // Basic query, consecutive beats, back-to-back handshake.
    beat(4'h1); beat(4'h2);
    exp_q.push_back('{vec: 12'h321, res: 2'b10});
    beat(4'h3);
    run_result(1'b0);

    // Consumer stalls for five cycles in DONE.
    beat(4'h7); beat(4'h8);
    exp_q.push_back('{vec: 12'h987, res: 2'b01});
    beat(4'h9);
    run_result(1'b1);

    // Gapped beats: invalid cycles carry junk that must not be captured.
    beat(4'h4);
    feat_data = 4'hF; tick(); check("gap1.busy", 32'(busy), 0);
    beat(4'h5);
    feat_data = 4'hE; tick(); check("gap2.busy", 32'(busy), 0);
    exp_q.push_back('{vec: 12'h654, res: 2'b11});
    beat(4'h6);
    run_result(1'b0);

    // Abort in the middle of the sweep.
    beat(4'hA); beat(4'hB); beat(4'hC);
    tick(); tick();
    check("abort.rom_addr_pre", 32'(rom_addr), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_load("abort_sweep");
    check("abort.res_data_hold", 32'(res_data), 3);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort.no_res", 32'(res_valid | busy), 0);
    end
    beat(4'hD); beat(4'h1);
    exp_q.push_back('{vec: 12'h21D, res: 2'b00});
    beat(4'h2);
    run_result(1'b0);

    // Abort coincident with the final beat.
    beat(4'h1); beat(4'h2);
    abort = 1'b1;
    beat(4'h3);
    abort = 1'b0;
    check_load("abort_last");
    beat(4'hC); check("abort_last.busy1", 32'(busy), 0);
    beat(4'hB); check("abort_last.busy2", 32'(busy), 0);
    exp_q.push_back('{vec: 12'hABC, res: 2'b01});
    beat(4'hA);
    run_result(1'b0);

    // Reset (with abort also high) during drain discards the query.
    beat(4'h3); beat(4'h3); beat(4'h3);
    core_result = 2'b11;
    for (int i = 0; i < CN + 1; i++) tick();
    check("rstdrain.rom_en",  32'(rom_en),  0);
    check("rstdrain.core_en", 32'(core_en), 1);
    rst = 1'b1; abort = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0;
    check_load("rst_drain");
    check("rst_drain.res_data", 32'(res_data), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rst_drain.no_res", 32'(res_valid | busy), 0);
    end

    check("sb.drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
